// File: rtl/riscv_program_loader.sv
// riscv_program_loader
//
// Byte-stream program loader that sits between an external download port and
// the core. It takes a framed byte stream, assembles little-endian 32-bit
// words, and writes them to consecutive instruction-memory addresses starting
// at 0. It then checks a trailing checksum byte and, on a match, releases the
// core by raising R_EN.
//
// Frame: count byte N, then 4N data bytes (word 0 first, LSB first), then one
// checksum byte equal to the sum of the data bytes modulo 256.
//
// Ports:
//   CLK            system clock, rising edge
//   RST            asynchronous active-low reset
//   START          one-cycle pulse that begins a load (honoured in IDLE/DONE only)
//   IN_VALID       byte-stream valid
//   IN_DATA[7:0]   byte-stream data
//   IN_READY       loader can accept a byte (a byte moves when VALID & READY)
//   W_EN           instruction-memory write strobe
//   ADDRESS        instruction-memory word address
//   W_INSTRUCTION  instruction word being written
//   R_EN           core run enable, high only after a verified load
//   BUSY           load in progress
//   DONE           last load verified OK
//   ERR            last load failed (bad count or bad checksum)
//
// Every output is a register. The flag outputs are decoded from the next state,
// so each one lines up with the cycle in which the state register holds that
// state.

module riscv_program_loader #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              IN_VALID,
    input  logic [7:0]        IN_DATA,
    output logic              IN_READY,
    output logic              W_EN,
    output logic [ADDR_W-1:0] ADDRESS,
    output logic [31:0]       W_INSTRUCTION,
    output logic              R_EN,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_LOAD,
        S_WRITE,
        S_CHECK,
        S_DONE
    } state_t;

    // The count byte is widened by one bit so that DEPTH = 256 is still
    // comparable without overflow.
    localparam logic [8:0] DEPTH_LIM = 9'(DEPTH);

    state_t            state, state_next;
    logic [7:0]        count, count_next;
    logic [7:0]        word_idx, word_idx_next;
    logic [1:0]        byte_idx, byte_idx_next;
    logic [31:0]       word_buf, word_buf_next;
    logic [7:0]        acc, acc_next;
    logic              err_next;
    logic [ADDR_W-1:0] address_next;
    logic [31:0]       w_instr_next;
    logic              accept;

    assign accept = IN_VALID && IN_READY;

    // Next-state and next-register logic. Every register holds by default.
    // START is only examined in IDLE and DONE. In those states IN_READY is
    // low, so a START can never coincide with a byte accept.
    always_comb begin
        state_next    = state;
        count_next    = count;
        word_idx_next = word_idx;
        byte_idx_next = byte_idx;
        word_buf_next = word_buf;
        acc_next      = acc;
        err_next      = ERR;
        address_next  = ADDRESS;
        w_instr_next  = W_INSTRUCTION;

        case (state)
            S_IDLE, S_DONE: begin
                if (START) begin
                    state_next    = S_HEADER;
                    err_next      = 1'b0;
                    acc_next      = 8'd0;
                    word_idx_next = 8'd0;
                    byte_idx_next = 2'd0;
                end
            end

            S_HEADER: begin
                if (accept) begin
                    if (IN_DATA == 8'd0 || {1'b0, IN_DATA} > DEPTH_LIM) begin
                        state_next = S_IDLE;
                        err_next   = 1'b1;
                    end else begin
                        count_next = IN_DATA;
                        state_next = S_LOAD;
                    end
                end
            end

            // The write word is taken from the freshly merged buffer, so the
            // byte accepted on this edge already appears in W_INSTRUCTION
            // during the WRITE cycle.
            S_LOAD: begin
                if (accept) begin
                    word_buf_next[{byte_idx, 3'b000} +: 8] = IN_DATA;
                    acc_next      = acc + IN_DATA;
                    byte_idx_next = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        state_next   = S_WRITE;
                        address_next = ADDR_W'(word_idx);
                        w_instr_next = word_buf_next;
                    end
                end
            end

            S_WRITE: begin
                word_idx_next = word_idx + 8'd1;
                byte_idx_next = 2'd0;
                if (word_idx + 8'd1 == count) begin
                    state_next = S_CHECK;
                end else begin
                    state_next = S_LOAD;
                end
            end

            S_CHECK: begin
                if (accept) begin
                    if (IN_DATA == acc) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_IDLE;
                        err_next   = 1'b1;
                    end
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and output registers. The flags are decoded from state_next, so
    // they change on the same edge as the state they describe.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state         <= S_IDLE;
            count         <= 8'd0;
            word_idx      <= 8'd0;
            byte_idx      <= 2'd0;
            word_buf      <= 32'd0;
            acc           <= 8'd0;
            IN_READY      <= 1'b0;
            W_EN          <= 1'b0;
            ADDRESS       <= '0;
            W_INSTRUCTION <= 32'd0;
            R_EN          <= 1'b0;
            BUSY          <= 1'b0;
            DONE          <= 1'b0;
            ERR           <= 1'b0;
        end else begin
            state         <= state_next;
            count         <= count_next;
            word_idx      <= word_idx_next;
            byte_idx      <= byte_idx_next;
            word_buf      <= word_buf_next;
            acc           <= acc_next;
            IN_READY      <= (state_next == S_HEADER) || (state_next == S_LOAD) ||
                             (state_next == S_CHECK);
            W_EN          <= (state_next == S_WRITE);
            ADDRESS       <= address_next;
            W_INSTRUCTION <= w_instr_next;
            R_EN          <= (state_next == S_DONE);
            BUSY          <= (state_next == S_HEADER) || (state_next == S_LOAD) ||
                             (state_next == S_WRITE) || (state_next == S_CHECK);
            DONE          <= (state_next == S_DONE);
            ERR           <= err_next;
        end
    end

endmodule
